// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use stall / branch flush control.
// A two-state FSM inserts one bubble per load-use hazard; branches flush IF/ID.
module if_id_hazard #(
  parameter logic [15:0] STALL_COUNT_INIT = 16'h0000,
  parameter logic [15:0] FLUSH_COUNT_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] PCAddResultIn,
  input  logic [31:0] InstructionIn,
  input  logic        IDEXMemRead,
  input  logic [4:0]  IDEXRtReg,
  input  logic        BranchTaken,
  output logic [31:0] PCAddResultOut,
  output logic [31:0] InstructionOut,
  output logic        ValidOut,
  output logic        PCWrite,
  output logic        FlushIDEX,
  output logic        StallState,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic [4:0]  rs, rt;
  logic        load_use;
  logic        stall_cond;

  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];

  // rt is compared even for instructions that do not read it (conservative)
  assign load_use   = valid_q & IDEXMemRead & (IDEXRtReg != 5'd0) &
                      ((IDEXRtReg == rs) | (IDEXRtReg == rt));
  assign stall_cond = (state_q == RUN) & load_use & ~BranchTaken;

  always_comb begin
    state_d     = RUN;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    PCWrite     = 1'b1;
    FlushIDEX   = 1'b0;

    if (Reset) begin
      PCWrite   = 1'b0;
      FlushIDEX = 1'b1;
    end else if (BranchTaken) begin
      pc_d        = 32'd0;
      instr_d     = 32'd0;
      valid_d     = 1'b0;
      FlushIDEX   = 1'b1;
      flush_cnt_d = (flush_cnt_q == 16'hFFFF) ? flush_cnt_q : flush_cnt_q + 16'd1;
    end else if (stall_cond) begin
      // hold IF/ID and the PC; the bubble goes into ID/EX
      state_d     = STALL;
      PCWrite     = 1'b0;
      FlushIDEX   = 1'b1;
      stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
    end else begin
      pc_d    = PCAddResultIn;
      instr_d = InstructionIn;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= RUN;
      pc_q        <= 32'd0;
      instr_q     <= 32'd0;
      valid_q     <= 1'b0;
      stall_cnt_q <= STALL_COUNT_INIT;
      flush_cnt_q <= FLUSH_COUNT_INIT;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PCAddResultOut = pc_q;
  assign InstructionOut = instr_q;
  assign ValidOut       = valid_q;
  assign StallState     = (state_q == STALL);
  assign StallCount     = stall_cnt_q;
  assign FlushCount     = flush_cnt_q;

endmodule

// File: tb/tb_if_id_hazard.sv
// Scoreboard bench for if_id_hazard: stimulus pushes hand-computed expectations,
// a monitor pops and compares each cycle; a second instance preloads StallCount.
module tb_if_id_hazard;
  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] PCAddResultIn, InstructionIn;
  logic        IDEXMemRead, BranchTaken;
  logic [4:0]  IDEXRtReg;

  logic [31:0] pc_out, ins_out;
  logic        valid_out, pc_write, flush_idex, stall_state;
  logic [15:0] stall_count, flush_count;

  logic [31:0] s_pc_out, s_ins_out;
  logic        s_valid_out, s_pc_write, s_flush_idex, s_stall_state;
  logic [15:0] s_stall_count, s_flush_count;

  int checks = 0;
  int failures = 0;
  int txn = 0;

  typedef struct {
    logic        pw, fl;
    logic [31:0] pc, ins;
    logic        v, ss;
    logic [15:0] sc, fc, sat;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  if_id_hazard dut (
    .clk(clk), .Reset(Reset), .PCAddResultIn(PCAddResultIn), .InstructionIn(InstructionIn),
    .IDEXMemRead(IDEXMemRead), .IDEXRtReg(IDEXRtReg), .BranchTaken(BranchTaken),
    .PCAddResultOut(pc_out), .InstructionOut(ins_out), .ValidOut(valid_out),
    .PCWrite(pc_write), .FlushIDEX(flush_idex), .StallState(stall_state),
    .StallCount(stall_count), .FlushCount(flush_count)
  );

  if_id_hazard #(.STALL_COUNT_INIT(16'hFFFE)) sat_dut (
    .clk(clk), .Reset(Reset), .PCAddResultIn(PCAddResultIn), .InstructionIn(InstructionIn),
    .IDEXMemRead(IDEXMemRead), .IDEXRtReg(IDEXRtReg), .BranchTaken(BranchTaken),
    .PCAddResultOut(s_pc_out), .InstructionOut(s_ins_out), .ValidOut(s_valid_out),
    .PCWrite(s_pc_write), .FlushIDEX(s_flush_idex), .StallState(s_stall_state),
    .StallCount(s_stall_count), .FlushCount(s_flush_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (txn %0d): got %h expected %h", name, txn, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h08, rs, rt, 16'h1234};
  endfunction

  // Drive one cycle of inputs (at posedge+2) and queue what the DUT must show.
  task automatic step(input logic [31:0] pc, input logic [31:0] ins, input logic mr,
                      input logic [4:0] rt, input logic br,
                      input logic epw, input logic efl, input logic [31:0] epc,
                      input logic [31:0] eins, input logic ev, input logic ess,
                      input logic [15:0] esc, input logic [15:0] efc);
    exp_t e;
    PCAddResultIn = pc;
    InstructionIn = ins;
    IDEXMemRead   = mr;
    IDEXRtReg     = rt;
    BranchTaken   = br;
    e.pw = epw; e.fl = efl; e.pc = epc; e.ins = eins; e.v = ev; e.ss = ess;
    e.sc = esc; e.fc = efc;
    e.sat = (esc == 16'd0) ? 16'hFFFE : 16'hFFFF;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("PCWrite", {31'd0, pc_write}, {31'd0, e.pw});
        chk("FlushIDEX", {31'd0, flush_idex}, {31'd0, e.fl});
        @(posedge clk);
        #1;
        chk("PCAddResultOut", pc_out, e.pc);
        chk("InstructionOut", ins_out, e.ins);
        chk("ValidOut", {31'd0, valid_out}, {31'd0, e.v});
        chk("StallState", {31'd0, stall_state}, {31'd0, e.ss});
        chk("StallCount", {16'd0, stall_count}, {16'd0, e.sc});
        chk("FlushCount", {16'd0, flush_count}, {16'd0, e.fc});
        chk("SatStallCount", {16'd0, s_stall_count}, {16'd0, e.sat});
        $display("txn %0d pc=%h ins=%h v=%0d ss=%0d sc=%0d fc=%0d", txn, pc_out, ins_out,
                 valid_out, stall_state, stall_count, flush_count);
        txn++;
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_pc"}, pc_out, 32'd0);
    chk({tag, "_ins"}, ins_out, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_stallstate"}, {31'd0, stall_state}, 32'd0);
    chk({tag, "_stallcnt"}, {16'd0, stall_count}, 32'd0);
    chk({tag, "_flushcnt"}, {16'd0, flush_count}, 32'd0);
    chk({tag, "_pcwrite"}, {31'd0, pc_write}, 32'd0);
    chk({tag, "_flushidex"}, {31'd0, flush_idex}, 32'd1);
    chk({tag, "_satcnt"}, {16'd0, s_stall_count}, 32'h0000FFFE);
  endtask

  initial begin
    Reset = 1'b1;
    PCAddResultIn = 32'd0; InstructionIn = 32'd0;
    IDEXMemRead = 1'b0; IDEXRtReg = 5'd0; BranchTaken = 1'b0;
    #1;
    reset_checks("reset");
    #2 Reset = 1'b0;
    @(posedge clk);
    #2;
    //   pc      instr          mr    rt     br    pw    fl    pc_out  ins_out        v     ss    sc  fc
    step(32'd4,  mk(5'd1,5'd2),  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'd4,  mk(5'd1,5'd2),  1'b1, 1'b0, 0, 0);
    step(32'd8,  mk(5'd3,5'd4),  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'd8,  mk(5'd3,5'd4),  1'b1, 1'b0, 0, 0);
    step(32'd12, mk(5'd8,5'd9),  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'd12, mk(5'd8,5'd9),  1'b1, 1'b0, 0, 0);
    // load-use on rs=8: hold, then advance (LoadUse ignored while in STALL)
    step(32'd16, mk(5'd5,5'd6),  1'b1, 5'd8,  1'b0, 1'b0, 1'b1, 32'd12, mk(5'd8,5'd9),  1'b1, 1'b1, 1, 0);
    step(32'd16, mk(5'd5,5'd6),  1'b1, 5'd8,  1'b0, 1'b1, 1'b0, 32'd16, mk(5'd5,5'd6),  1'b1, 1'b0, 1, 0);
    // no false stalls: MemRead=0 with rt match; IDEXRtReg=0 with rs=0
    step(32'd20, mk(5'd0,5'd7),  1'b0, 5'd6,  1'b0, 1'b1, 1'b0, 32'd20, mk(5'd0,5'd7),  1'b1, 1'b0, 1, 0);
    step(32'd24, mk(5'd10,5'd11),1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 32'd24, mk(5'd10,5'd11),1'b1, 1'b0, 1, 0);
    // load-use on rt=11
    step(32'd28, mk(5'd12,5'd13),1'b1, 5'd11, 1'b0, 1'b0, 1'b1, 32'd24, mk(5'd10,5'd11),1'b1, 1'b1, 2, 0);
    step(32'd28, mk(5'd12,5'd13),1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'd28, mk(5'd12,5'd13),1'b1, 1'b0, 2, 0);
    // branch together with load-use: flush only
    step(32'd32, mk(5'd14,5'd15),1'b1, 5'd12, 1'b1, 1'b1, 1'b1, 32'd0,  32'd0,          1'b0, 1'b0, 2, 1);
    step(32'd32, mk(5'd14,5'd15),1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 32'd32, mk(5'd14,5'd15),1'b1, 1'b0, 2, 1);
    // stall, then branch while in STALL
    step(32'd36, mk(5'd2,5'd3),  1'b1, 5'd14, 1'b0, 1'b0, 1'b1, 32'd32, mk(5'd14,5'd15),1'b1, 1'b1, 3, 1);
    step(32'd36, mk(5'd2,5'd3),  1'b0, 5'd0,  1'b1, 1'b1, 1'b1, 32'd0,  32'd0,          1'b0, 1'b0, 3, 2);
    step(32'd40, mk(5'd16,5'd17),1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'd40, mk(5'd16,5'd17),1'b1, 1'b0, 3, 2);
    // enter STALL, then pulse Reset between edges
    step(32'd44, mk(5'd1,5'd1),  1'b1, 5'd16, 1'b0, 1'b0, 1'b1, 32'd40, mk(5'd16,5'd17),1'b1, 1'b1, 4, 2);
    #1 Reset = 1'b1;
    #1;
    reset_checks("midstall_reset");
    Reset = 1'b0;
    step(32'd44, mk(5'd1,5'd1),  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'd44, mk(5'd1,5'd1),  1'b1, 1'b0, 0, 0);
    step(32'd48, mk(5'd2,5'd2),  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'd48, mk(5'd2,5'd2),  1'b1, 1'b0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d transactions left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
